// File: rtl/deck_shuffler.sv
// Deck source: builds the 52-card deck, optionally Fisher-Yates shuffles it with a
// 16-bit Galois LFSR, then streams one 7-bit card {rank, suit, visible} per
// valid/ready beat.
// Optional feature: define DECK_SHUFFLE_EN to include the SHUFFLE state; without it the
// ordered deck (index = suit*13 + rank-1) is streamed and the LFSR runs unused.
module deck_shuffler #(
  parameter logic [15:0] SEED    = 16'hACE1,
  parameter logic        FACE_UP = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       card_valid,
  input  logic       card_ready,
  output logic [6:0] card_out,
  output logic [5:0] card_index,
  output logic       done
);

  typedef enum logic [2:0] {StIdle, StInit, StShuffle, StStream, StDone} state_e;

  localparam logic [15:0] LfsrInit = (SEED == 16'h0000) ? 16'hACE1 : SEED;
  localparam logic [15:0] LfsrMask = 16'hB400;
  localparam logic [5:0]  LastIdx  = 6'd51;

  state_e      state_q, state_d;
  // Shared position counter: k while filling, i while shuffling, idx while streaming.
  logic [5:0]  k_q, k_d;
  logic [3:0]  rank_q, rank_d;
  logic [1:0]  suit_q, suit_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic        init_we;
  logic [6:0]  deck_q [52];

`ifdef DECK_SHUFFLE_EN
  logic [5:0]  rnd;
  logic        swap_en;
  assign rnd = lfsr_q[5:0];
`endif

  // Right-shifting Galois LFSR, advances every non-reset cycle.
  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LfsrMask : 16'h0000);
  end

  // LFSR register.
  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= LfsrInit;
    else     lfsr_q <= lfsr_d;
  end

  // Next-state and counter logic.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    rank_d  = rank_q;
    suit_d  = suit_q;
    init_we = 1'b0;
`ifdef DECK_SHUFFLE_EN
    swap_en = 1'b0;
`endif
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StInit;
          k_d     = 6'd0;
          rank_d  = 4'd1;
          suit_d  = 2'd0;
        end
      end
      StInit: begin
        init_we = 1'b1;
        if (k_q == LastIdx) begin
`ifdef DECK_SHUFFLE_EN
          state_d = StShuffle;
          k_d     = LastIdx;
`else
          state_d = StStream;
          k_d     = 6'd0;
`endif
        end else begin
          k_d = k_q + 6'd1;
          if (rank_q == 4'd13) begin
            rank_d = 4'd1;
            suit_d = suit_q + 2'd1;
          end else begin
            rank_d = rank_q + 4'd1;
          end
        end
      end
`ifdef DECK_SHUFFLE_EN
      StShuffle: begin
        // Draws above i are rejected and retried next cycle to keep the shuffle unbiased.
        if (rnd <= k_q) begin
          swap_en = 1'b1;
          if (k_q == 6'd1) begin
            state_d = StStream;
            k_d     = 6'd0;
          end else begin
            k_d = k_q - 6'd1;
          end
        end
      end
`endif
      StStream: begin
        if (card_ready) begin
          if (k_q == LastIdx) begin
            state_d = StDone;
            k_d     = 6'd0;
          end else begin
            k_d = k_q + 6'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      k_q     <= 6'd0;
      rank_q  <= 4'd0;
      suit_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      rank_q  <= rank_d;
      suit_q  <= suit_d;
    end
  end

  // Deck storage; contents are meaningless outside STREAM so it needs no reset.
  always_ff @(posedge clk) begin
    if (init_we) begin
      deck_q[k_q] <= {rank_q, suit_q, FACE_UP};
`ifdef DECK_SHUFFLE_EN
    end else if (swap_en) begin
      deck_q[k_q] <= deck_q[rnd];
      deck_q[rnd] <= deck_q[k_q];
`endif
    end
  end

  // Outputs decoded from state; card fields forced to zero when not streaming.
  always_comb begin
    busy       = (state_q == StInit) || (state_q == StShuffle) || (state_q == StStream);
    card_valid = (state_q == StStream);
    done       = (state_q == StDone);
    card_out   = card_valid ? deck_q[k_q] : 7'd0;
    card_index = card_valid ? k_q : 6'd0;
  end

endmodule

// File: tb/tb_deck_shuffler.sv
// Directed bench for deck_shuffler: reset state, first-card latency, full deck contents,
// backpressure hold, start ignored while streaming, restart from DONE, mid-run reset
// reproducibility, and FACE_UP=1 visibility bit (second instance).
module tb_deck_shuffler;

  logic       clk;
  logic       rst;
  logic       start;
  logic       card_ready;
  logic       busy, card_valid, done;
  logic [6:0] card_out;
  logic [5:0] card_index;
  logic       fu_busy, fu_valid, fu_done;
  logic [6:0] fu_card;
  logic [5:0] fu_index;

  int errors = 0;
  int checks = 0;
  logic [6:0] seq1 [52];
  int seen [64];
  int cnt;
  logic [6:0] held;

  deck_shuffler #(.SEED(16'hACE1), .FACE_UP(1'b0)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .card_valid(card_valid),
    .card_ready(card_ready), .card_out(card_out), .card_index(card_index), .done(done)
  );

  deck_shuffler #(.SEED(16'hACE1), .FACE_UP(1'b1)) dut_fu (
    .clk(clk), .rst(rst), .start(start), .busy(fu_busy), .card_valid(fu_valid),
    .card_ready(card_ready), .card_out(fu_card), .card_index(fu_index), .done(fu_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Ticks until card_valid rises or the budget runs out; returns ticks taken.
  task automatic wait_valid(input int budget, output int n);
    n = 0;
    while (card_valid !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
  endtask

  function automatic logic [6:0] exp_card(input int n, input logic fu);
    logic [3:0] rk;
    logic [1:0] st;
    rk = 4'(n % 13 + 1);
    st = 2'(n / 13);
    return {rk, st, fu};
  endfunction

  initial begin
    rst = 1'b1;
    start = 1'b0;
    card_ready = 1'b0;
    for (int i = 0; i < 64; i++) seen[i] = 0;

    // Reset state
    tick();
    tick();
    chk("rst_busy", busy, 1'b0);
    chk("rst_valid", card_valid, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_card", card_out, 7'h00);
    chk("rst_index", card_index, 6'd0);
    chk("rst_fu_all", {fu_busy, fu_valid, fu_done, fu_card, fu_index}, 32'h0);

    // First deck: latency and contents, ready held high
    rst = 1'b0;
    tick();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("init_busy", busy, 1'b1);
    chk("init_valid", card_valid, 1'b0);
    wait_valid(5000, cnt);
    chk("first_valid", card_valid, 1'b1);
`ifndef DECK_SHUFFLE_EN
    chk("latency", cnt, 52);
`endif
    card_ready = 1'b1;
    for (int n = 0; n < 52; n++) begin
      chk($sformatf("idx%0d", n), card_index, n[5:0]);
      chk($sformatf("done_lo%0d", n), done, 1'b0);
      chk($sformatf("fu_vis%0d", n), fu_card[0], 1'b1);
      seq1[n] = card_out;
      seen[card_out[6:1]]++;
`ifndef DECK_SHUFFLE_EN
      chk($sformatf("card%0d", n), card_out, exp_card(n, 1'b0));
      chk($sformatf("fu_card%0d", n), fu_card, exp_card(n, 1'b1));
`endif
      tick();
    end
    chk("deck1_done", done, 1'b1);
    chk("deck1_valid_off", card_valid, 1'b0);
    chk("deck1_busy_off", busy, 1'b0);
    chk("fu_done", fu_done, 1'b1);
    cnt = 0;
    for (int r = 1; r <= 13; r++)
      for (int s = 0; s < 4; s++)
        if (seen[r * 4 + s] == 1) cnt++;
    chk("permutation", cnt, 52);
`ifndef DECK_SHUFFLE_EN
    chk("heart_A", seq1[0], 7'h08);
    chk("heart_2", seq1[1], 7'h10);
    chk("heart_K", seq1[12], 7'h68);
    chk("club_A", seq1[13], 7'h0A);
    chk("spade_K", seq1[51], 7'h6E);
`else
    cnt = 0;
    for (int n = 0; n < 52; n++) if (seq1[n] !== exp_card(n, 1'b0)) cnt++;
    chk("shuffled", (cnt != 0), 1'b1);
`endif

    // Restart from DONE, backpressure at index 2, start ignored while streaming
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_done", done, 1'b0);
    chk("restart_busy", busy, 1'b1);
    wait_valid(5000, cnt);
    chk("deck2_valid", card_valid, 1'b1);
    tick();
    tick();
    chk("bp_idx", card_index, 6'd2);
    card_ready = 1'b0;
    held = card_out;
`ifndef DECK_SHUFFLE_EN
    chk("bp_card", held, 7'h18);
`endif
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("hold_idx%0d", c), card_index, 6'd2);
      chk($sformatf("hold_valid%0d", c), card_valid, 1'b1);
      chk($sformatf("hold_card%0d", c), card_out, held);
    end
    card_ready = 1'b1;
    tick();
    chk("resume_idx", card_index, 6'd3);
`ifndef DECK_SHUFFLE_EN
    chk("resume_card", card_out, 7'h20);
`endif
    repeat (7) tick();
    chk("pre_start_idx", card_index, 6'd10);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ign_start_idx", card_index, 6'd11);
    chk("ign_start_valid", card_valid, 1'b1);
    repeat (40) tick();
    chk("deck2_last_idx", card_index, 6'd51);
    tick();
    chk("deck2_done", done, 1'b1);
    chk("deck2_valid_off", card_valid, 1'b0);

    // Reset mid-operation, then rerun with the same post-reset timing as deck 1
    start = 1'b1;
    tick();
    start = 1'b0;
`ifndef DECK_SHUFFLE_EN
    repeat (20) tick();
`else
    repeat (60) tick();
`endif
    chk("mid_busy", busy, 1'b1);
    rst = 1'b1;
    tick();
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_valid", card_valid, 1'b0);
    chk("mid_rst_done", done, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid(5000, cnt);
    chk("deck3_valid", card_valid, 1'b1);
`ifndef DECK_SHUFFLE_EN
    chk("deck3_latency", cnt, 52);
`endif
    for (int n = 0; n < 52; n++) begin
      chk($sformatf("repro%0d", n), card_out, seq1[n]);
      tick();
    end
    chk("deck3_done", done, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
